// File: rtl/sudoku_pkg.sv
// -----------------------------------------------------------------------------
// sudoku_pkg
//   Shared definitions for the game-entry controller and the hex display
//   stages that consume its outputs.
//     ESTADO_W        width of the estadoJogo cell index
//     HEX_APAGADO     digit code the display stages use for a blank cell
//     NUM_CELULAS_DEF default number of digit cells
//     estado_t        controller FSM states
// -----------------------------------------------------------------------------
package sudoku_pkg;

  localparam int          ESTADO_W        = 3;
  localparam logic [3:0]  HEX_APAGADO     = 4'hE;
  localparam int          NUM_CELULAS_DEF = 4;

  typedef enum logic {
    ENTRADA  = 1'b0,
    COMPLETO = 1'b1
  } estado_t;

endpackage

// File: rtl/debounce_botao.sv
// -----------------------------------------------------------------------------
// debounce_botao
//   Cleans one raw active-low key: 2-FF synchronizer, a stability counter, and
//   a registered one-cycle pulse on each debounced press (stable 1 -> 0).
//   Ports:
//     clk      in  clock
//     reset    in  asynchronous, active-high; key reads as released afterwards
//     btn_n_i  in  raw key, active-low, asynchronous to clk
//     press_o  out one-cycle press pulse
// -----------------------------------------------------------------------------
module debounce_botao #(
  parameter int DEBOUNCE_CICLOS = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronized level differs from the
  // stable level; any return to the stable level reloads it, so a bounce has
  // to persist for DEBOUNCE_CICLOS consecutive samples to be accepted.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = stable_q;  // released -> pressed only
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sudoku_entrada_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_entrada_ctrl
//   Game-entry controller: debounces the confirm/back keys, stores switchCod
//   into the current cell on confirm, and moves the shared estadoJogo index
//   that the display stages compare against their own position.
//   Ports:
//     clk           in  clock
//     reset         in  asynchronous, active-high
//     btn_confirma  in  raw confirm key, active-low
//     btn_volta     in  raw back key, active-low
//     switchCod     in  digit code from the switches (quasi-static)
//     estadoJogo    out index of the cell being entered (NUM_CELULAS = done)
//     registradores out cell i in bits [4i+3:4i]
//     concluido     out high while every cell is filled
//     erro          out one-cycle pulse on a rejected digit
//   Build option: VALIDA_DIGITO_EN -- reject codes 0 and > MAX_DIGITO; when
//   undefined every code is accepted and erro stays 0.
// -----------------------------------------------------------------------------
module sudoku_entrada_ctrl
  import sudoku_pkg::*;
#(
  parameter int NUM_CELULAS     = NUM_CELULAS_DEF,
  parameter int DEBOUNCE_CICLOS = 1_000_000,
  parameter int MAX_DIGITO      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_confirma,
  input  logic                     btn_volta,
  input  logic [3:0]               switchCod,
  output logic [ESTADO_W-1:0]      estadoJogo,
  output logic [4*NUM_CELULAS-1:0] registradores,
  output logic                     concluido,
  output logic                     erro
);

`ifdef VALIDA_DIGITO_EN
  localparam bit VALIDA = 1'b1;
`else
  localparam bit VALIDA = 1'b0;
`endif

  localparam logic [ESTADO_W-1:0] IDX_FIM = ESTADO_W'(NUM_CELULAS);

  logic conf_pulse, volta_pulse;
  logic conf, volta, aceita;

  estado_t                  state_q, state_d;
  logic [ESTADO_W-1:0]      idx_q, idx_d;
  logic [4*NUM_CELULAS-1:0] regs_q, regs_d;
  logic                     erro_q, erro_d;

  debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_confirma (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (btn_confirma),
    .press_o (conf_pulse)
  );

  debounce_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_deb_volta (
    .clk     (clk),
    .reset   (reset),
    .btn_n_i (btn_volta),
    .press_o (volta_pulse)
  );

  // Coincident pulses cancel each other.
  assign conf   = conf_pulse & ~volta_pulse;
  assign volta  = volta_pulse & ~conf_pulse;
  assign aceita = !VALIDA || ((switchCod != 4'h0) && (int'(switchCod) <= MAX_DIGITO));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENTRADA;
      idx_q   <= '0;
      regs_q  <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    erro_d  = 1'b0;
    unique case (state_q)
      ENTRADA: begin
        if (conf) begin
          if (aceita) begin
            for (int i = 0; i < NUM_CELULAS; i++) begin
              if (idx_q == ESTADO_W'(i)) regs_d[4*i +: 4] = switchCod;
            end
            idx_d = idx_q + 1'b1;
            if (idx_d == IDX_FIM) state_d = COMPLETO;
          end else begin
            erro_d = 1'b1;
          end
        end else if (volta && (idx_q != '0)) begin
          idx_d = idx_q - 1'b1;
          for (int i = 0; i < NUM_CELULAS; i++) begin
            if (idx_d == ESTADO_W'(i)) regs_d[4*i +: 4] = 4'h0;
          end
        end
      end
      COMPLETO: begin
        // Confirm has nothing left to fill; only back leaves this state.
        if (volta) begin
          idx_d   = IDX_FIM - 1'b1;
          regs_d[4*(NUM_CELULAS-1) +: 4] = 4'h0;
          state_d = ENTRADA;
        end
      end
      default: state_d = ENTRADA;
    endcase
  end

  always_comb begin
    estadoJogo    = idx_q;
    registradores = regs_q;
    concluido     = (state_q == COMPLETO);
    erro          = erro_q;
  end

endmodule

// File: tb/tb_sudoku_entrada_ctrl.sv
module tb_sudoku_entrada_ctrl;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int MAXD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_confirma = 1'b1;
  logic        btn_volta = 1'b1;
  logic [3:0]  switchCod = 4'h0;
  logic [2:0]  estadoJogo;
  logic [15:0] registradores;
  logic        concluido;
  logic        erro;

  int checks = 0;
  int failures = 0;
  int n_erro = 0;

  sudoku_entrada_ctrl #(
    .NUM_CELULAS     (N),
    .DEBOUNCE_CICLOS (DEB),
    .MAX_DIGITO      (MAXD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_confirma  (btn_confirma),
    .btn_volta     (btn_volta),
    .switchCod     (switchCod),
    .estadoJogo    (estadoJogo),
    .registradores (registradores),
    .concluido     (concluido),
    .erro          (erro)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_idx = 0;
  logic [3:0] m_cell [N];
  logic       m_erro = 1'b0;
  logic       k_d1 [2];
  logic       k_d2 [2];
  logic       k_st [2];
  logic       k_win [2][DEB];
  logic       k_pend [2];
  logic       raw [2];
  logic       seen;
  bit         all_diff;

  function automatic bit digito_ok(input logic [3:0] s);
`ifdef VALIDA_DIGITO_EN
    return (s != 4'h0) && (int'(s) <= MAXD);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [15:0] pack_cells();
    logic [15:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = m_cell[i];
    return v;
  endfunction

  // A key is accepted once the last DEB synchronized samples all disagree
  // with its stable level; the press acts on the game one clock later.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_idx  = 0;
        m_erro = 1'b0;
        for (int i = 0; i < N; i++) m_cell[i] = 4'h0;
        for (int k = 0; k < 2; k++) begin
          k_d1[k] = 1'b1; k_d2[k] = 1'b1; k_st[k] = 1'b1; k_pend[k] = 1'b0;
          for (int j = 0; j < DEB; j++) k_win[k][j] = 1'b1;
        end
      end else begin
        m_erro = 1'b0;
        if (k_pend[0] && !k_pend[1] && m_idx < N) begin
          if (digito_ok(switchCod)) begin
            m_cell[m_idx] = switchCod;
            m_idx++;
          end else begin
            m_erro = 1'b1;
          end
        end else if (k_pend[1] && !k_pend[0] && m_idx > 0) begin
          m_idx--;
          m_cell[m_idx] = 4'h0;
        end
        raw[0] = btn_confirma;
        raw[1] = btn_volta;
        for (int k = 0; k < 2; k++) begin
          seen    = k_d2[k];
          k_d2[k] = k_d1[k];
          k_d1[k] = raw[k];
          for (int j = DEB - 1; j > 0; j--) k_win[k][j] = k_win[k][j-1];
          k_win[k][0] = seen;
          all_diff = 1'b1;
          for (int j = 0; j < DEB; j++) if (k_win[k][j] == k_st[k]) all_diff = 1'b0;
          k_pend[k] = 1'b0;
          if (all_diff) begin
            k_st[k]   = ~k_st[k];
            k_pend[k] = (k_st[k] == 1'b0);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("estadoJogo", 32'(estadoJogo), 32'(m_idx));
      chk("registradores", 32'(registradores), 32'(pack_cells()));
      chk("concluido", 32'(concluido), 32'(m_idx == N));
      chk("erro", 32'(erro), 32'(m_erro));
      if (erro) n_erro++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic aperta(input bit c, input bit v, input int hold);
    @(negedge clk);
    if (c) btn_confirma = 1'b0;
    if (v) btn_volta = 1'b0;
    repeat (hold) @(negedge clk);
    btn_confirma = 1'b1;
    btn_volta    = 1'b1;
    repeat (12) @(negedge clk);
    #1;
  endtask

  task automatic estado_lit(input string nm, input int e, input logic [15:0] r, input bit fim);
    chk({nm, "_estado"}, 32'(estadoJogo), 32'(e));
    chk({nm, "_regs"}, 32'(registradores), 32'(r));
    chk({nm, "_concluido"}, 32'(concluido), 32'(fim));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    estado_lit("reset", 0, 16'h0000, 1'b0);
    chk("reset_erro", 32'(erro), 32'h0);

    // Digit validation: code 0 then 5
    switchCod = 4'h0;
    aperta(1'b1, 1'b0, 6);
    switchCod = 4'h5;
    aperta(1'b1, 1'b0, 6);
`ifdef VALIDA_DIGITO_EN
    chk("valida_erro_pulsos", 32'(n_erro), 32'd2);
    estado_lit("valida", 0, 16'h0000, 1'b0);
`else
    chk("valida_erro_pulsos", 32'(n_erro), 32'd0);
    estado_lit("valida", 2, 16'h0050, 1'b0);
`endif

    // Mid-cycle reset with a press still being debounced
    @(negedge clk);
    btn_confirma = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    estado_lit("reset_async", 0, 16'h0000, 1'b0);
    @(negedge clk);
    btn_confirma = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    estado_lit("pendente_perdido", 0, 16'h0000, 1'b0);

    // Entry 3,1,4,2
    switchCod = 4'h3; aperta(1'b1, 1'b0, 6); estado_lit("entrada1", 1, 16'h0003, 1'b0);
    switchCod = 4'h1; aperta(1'b1, 1'b0, 6); estado_lit("entrada2", 2, 16'h0013, 1'b0);
    switchCod = 4'h4; aperta(1'b1, 1'b0, 6); estado_lit("entrada3", 3, 16'h0413, 1'b0);
    switchCod = 4'h2; aperta(1'b1, 1'b0, 6); estado_lit("entrada4", 4, 16'h2413, 1'b1);

    // COMPLETO: confirm ignored, both keys ignored, back reopens last cell
    switchCod = 4'h1; aperta(1'b1, 1'b0, 6); estado_lit("completo_conf", 4, 16'h2413, 1'b1);
    aperta(1'b1, 1'b1, 6);                    estado_lit("ambos", 4, 16'h2413, 1'b1);
    aperta(1'b0, 1'b1, 6);                    estado_lit("completo_volta", 3, 16'h0413, 1'b0);

    // Back down to 0, then one more back at 0
    aperta(1'b0, 1'b1, 6); estado_lit("volta2", 2, 16'h0013, 1'b0);
    aperta(1'b0, 1'b1, 6); estado_lit("volta1", 1, 16'h0003, 1'b0);
    aperta(1'b0, 1'b1, 6); estado_lit("volta0", 0, 16'h0000, 1'b0);
    aperta(1'b0, 1'b1, 6); estado_lit("volta_em0", 0, 16'h0000, 1'b0);

    // Bounce: 3-cycle glitch rejected, 10-cycle hold gives one advance
    switchCod = 4'h2;
    aperta(1'b1, 1'b0, 3);  estado_lit("glitch", 0, 16'h0000, 1'b0);
    aperta(1'b1, 1'b0, 10); estado_lit("segurado", 1, 16'h0002, 1'b0);

    // Asynchronous reset from a non-zero state
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    estado_lit("reset_final", 0, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
